// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong write-buffer sequencer.
package pingpong_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Beats recorded for a bank never exceed its capacity.
    function automatic logic [8:0] clip_count(input logic [8:0] beats, input logic [8:0] depth);
        return (beats > depth) ? depth : beats;
    endfunction

endpackage

// File: rtl/pingpong_buf_ctrl_if.sv
// AXI4 write-channel control signals seen by the ping-pong buffer sequencer.
interface pingpong_buf_ctrl_if;

    logic       s_axi_awvalid_i;
    logic       s_axi_awready_o;
    logic [7:0] s_axi_awlen_i;
    logic       s_axi_wvalid_i;
    logic       s_axi_wready_o;
    logic       s_axi_wlast_i;
    logic       s_axi_bvalid_o;
    logic       s_axi_bready_i;
    logic [1:0] s_axi_bresp_o;

    modport master (
        output s_axi_awvalid_i, s_axi_awlen_i, s_axi_wvalid_i, s_axi_wlast_i, s_axi_bready_i,
        input  s_axi_awready_o, s_axi_wready_o, s_axi_bvalid_o, s_axi_bresp_o
    );

    modport slave (
        input  s_axi_awvalid_i, s_axi_awlen_i, s_axi_wvalid_i, s_axi_wlast_i, s_axi_bready_i,
        output s_axi_awready_o, s_axi_wready_o, s_axi_bvalid_o, s_axi_bresp_o
    );

endinterface

// File: rtl/pingpong_bank_tracker.sv
// Ownership state and recorded beat count of one buffer bank.
module pingpong_bank_tracker
    import pingpong_pkg::*;
#(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill_start,
    input  logic             fill_done,
    input  logic [CNT_W-1:0] fill_count,
    input  logic             drain_start,
    input  logic             drain_done,
    output bank_state_e      state,
    output logic [CNT_W-1:0] count
);

    // The four events are mutually exclusive for one bank given its current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            count <= '0;
        end else if (fill_start) begin
            state <= FILLING;
        end else if (fill_done) begin
            state <= FULL;
            count <= fill_count;
        end else if (drain_start) begin
            state <= DRAINING;
        end else if (drain_done) begin
            state <= EMPTY;
        end
    end

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Two-bank ping-pong write-buffer sequencer: AXI write side fills, consumer drains, banks alternate.
module pingpong_buf_ctrl
    import pingpong_pkg::*;
#(
    parameter int DEPTH_g  = 256,
    parameter int BEAT_W_g = $clog2(DEPTH_g)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    pingpong_buf_ctrl_if.slave  axi,
    output logic                wr_en_o,
    output logic                wr_bank_o,
    output logic [BEAT_W_g-1:0] wr_beat_o,
    output logic                rd_valid_o,
    input  logic                rd_ready_i,
    output logic                rd_bank_o,
    output logic [BEAT_W_g:0]   rd_count_o,
    input  logic                rd_done_i
);

    localparam int CNT_W = BEAT_W_g + 1;
    localparam logic [8:0] DEPTH_C = 9'(DEPTH_g);

    localparam logic [1:0] ST_IDLE = W_IDLE;
    localparam logic [1:0] ST_DATA = W_DATA;
    localparam logic [1:0] ST_RESP = W_RESP;

    logic [1:0]       wr_state;
    logic             fill_ptr;
    logic             drain_ptr;
    logic [7:0]       awlen_q;
    logic [8:0]       beat_cnt;
    logic             err;

    bank_state_e      bank_st  [2];
    logic [CNT_W-1:0] bank_cnt [2];

    logic aw_hs, w_hs, b_hs, rd_hs;
    logic at_len, beat_over, burst_end, drain_done;
    logic [CNT_W-1:0] fill_count;

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign axi.s_axi_awready_o = rst_n_i && (wr_state == ST_IDLE) && (bank_st[fill_ptr] == EMPTY);
    assign axi.s_axi_wready_o  = (wr_state == ST_DATA);
    assign axi.s_axi_bvalid_o  = (wr_state == ST_RESP);
    assign axi.s_axi_bresp_o   = ((wr_state == ST_RESP) && err) ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs = axi.s_axi_awvalid_i && axi.s_axi_awready_o;
    assign w_hs  = axi.s_axi_wvalid_i && axi.s_axi_wready_o;
    assign b_hs  = axi.s_axi_bvalid_o && axi.s_axi_bready_i;

    assign at_len     = (beat_cnt == {1'b0, awlen_q});
    assign beat_over  = (beat_cnt >= DEPTH_C);
    assign burst_end  = w_hs && (axi.s_axi_wlast_i || at_len);
    assign fill_count = CNT_W'(clip_count(beat_cnt + 9'd1, DEPTH_C));

    assign wr_en_o   = w_hs && !beat_over;
    assign wr_bank_o = fill_ptr;
    assign wr_beat_o = beat_cnt[BEAT_W_g-1:0];

    assign rd_valid_o = (bank_st[drain_ptr] == FULL);
    assign rd_bank_o  = drain_ptr;
    assign rd_count_o = bank_cnt[drain_ptr];
    assign rd_hs      = rd_valid_o && rd_ready_i;
    assign drain_done = rd_done_i && (bank_st[drain_ptr] == DRAINING);

    for (genvar g = 0; g < 2; g++) begin : g_bank
        pingpong_bank_tracker #(
            .CNT_W (CNT_W)
        ) u_tracker (
            .clk         (clk_i),
            .rst_n       (rst_n_i),
            .fill_start  (aw_hs && (fill_ptr == 1'(g))),
            .fill_done   (burst_end && (fill_ptr == 1'(g))),
            .fill_count  (fill_count),
            .drain_start (rd_hs && (drain_ptr == 1'(g))),
            .drain_done  (drain_done && (drain_ptr == 1'(g))),
            .state       (bank_st[g]),
            .count       (bank_cnt[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_state  <= ST_IDLE;
            fill_ptr  <= 1'b0;
            drain_ptr <= 1'b0;
            awlen_q   <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            case (wr_state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        awlen_q  <= axi.s_axi_awlen_i;
                        beat_cnt <= '0;
                        err      <= 1'b0;
                        wr_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        // Overflowing beats and a wlast/awlen disagreement both flag SLVERR.
                        if (beat_over || (burst_end && (axi.s_axi_wlast_i != at_len))) begin
                            err <= 1'b1;
                        end
                        if (burst_end) begin
                            fill_ptr <= ~fill_ptr;
                            wr_state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (b_hs) begin
                        wr_state <= ST_IDLE;
                    end
                end
                default: wr_state <= ST_IDLE;
            endcase
            if (drain_done) begin
                drain_ptr <= ~drain_ptr;
            end
        end
    end

endmodule
